// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
//
// Execute stage that sits between the register file read ports and its write
// port. A decoded instruction is accepted over a valid/ready handshake. The
// register-file read addresses are driven combinationally from the offered
// instruction. The returned operands are captured on the accept edge. The stage
// then either executes a single-cycle ALU op or runs an iterative shift-and-add
// multiply over DSIZE cycles. Results return as a one-cycle write-back pulse.
//
// Parameters:
//   DSIZE    datapath width (must match register-file data width)
//   ASIZE    register address width (must match register-file address width)
//
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous active-high reset
//   in_valid instruction offered
//   in_ready stage can accept (high only in IDLE)
//   in_op    opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 MUL, 7 NOP
//   in_rs1   source register 1
//   in_rs2   source register 2
//   in_rd    destination register
//   raddr1   register-file read address 1 (copy of in_rs1)
//   raddr2   register-file read address 2 (copy of in_rs2)
//   rdata1   register-file read data 1 (forwarded same-cycle writes included)
//   rdata2   register-file read data 2 (forwarded same-cycle writes included)
//   wen      write-back enable, one-cycle pulse
//   waddr    write-back register
//   wdata    write-back data
//   busy     high while a multiply is iterating
// -----------------------------------------------------------------------------
module alu_exec_stage #(
    parameter int DSIZE = 16,
    parameter int ASIZE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [ASIZE-1:0] in_rs1,
    input  logic [ASIZE-1:0] in_rs2,
    input  logic [ASIZE-1:0] in_rd,
    output logic [ASIZE-1:0] raddr1,
    output logic [ASIZE-1:0] raddr2,
    input  logic [DSIZE-1:0] rdata1,
    input  logic [DSIZE-1:0] rdata2,
    output logic             wen,
    output logic [ASIZE-1:0] waddr,
    output logic [DSIZE-1:0] wdata,
    output logic             busy
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MUL  = 1'b1;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_NOP = 3'd7;

    localparam int CW = $clog2(DSIZE) + 1;

    logic [0:0]       state;
    logic [DSIZE-1:0] mul_a;
    logic [DSIZE-1:0] mul_b;
    logic [DSIZE-1:0] acc;
    logic [CW-1:0]    cnt;
    logic [ASIZE-1:0] mul_rd;

    logic             accept;
    logic [DSIZE-1:0] alu_result;
    logic [DSIZE-1:0] acc_next;
    logic             last_iter;

    // Read addresses go straight out so the register file returns operands
    // in the same cycle the instruction is offered.
    assign raddr1   = in_rs1;
    assign raddr2   = in_rs2;

    assign in_ready = (state == IDLE);
    assign busy     = (state == MUL);
    assign accept   = in_valid && in_ready;

    // One shift-and-add step; the final step's value is the write-back data.
    assign acc_next  = mul_b[0] ? acc + mul_a : acc;
    assign last_iter = (cnt == CW'(DSIZE - 1));

    always_comb begin
        // NOTE: default assignment first so no path leaves alu_result unassigned (no latch).
        alu_result = '0;
        case (in_op)
            OP_ADD:  alu_result = rdata1 + rdata2;
            OP_SUB:  alu_result = rdata1 - rdata2;
            OP_AND:  alu_result = rdata1 & rdata2;
            OP_OR:   alu_result = rdata1 | rdata2;
            OP_XOR:  alu_result = rdata1 ^ rdata2;
            OP_SLT:  alu_result = DSIZE'($signed(rdata1) < $signed(rdata2));
            default: alu_result = '0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            mul_a  <= '0;
            mul_b  <= '0;
            acc    <= '0;
            cnt    <= '0;
            mul_rd <= '0;
            wen    <= 1'b0;
            waddr  <= '0;
            wdata  <= '0;
        end else begin
            // Write-back is a pulse: it only survives a cycle if re-asserted.
            wen <= 1'b0;

            if (state == IDLE) begin
                if (accept) begin
                    if (in_op == OP_MUL) begin
                        mul_a  <= rdata1;
                        mul_b  <= rdata2;
                        mul_rd <= in_rd;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= MUL;
                    end else if (in_op != OP_NOP && in_rd != '0) begin
                        // waddr/wdata only move on a real write so they hold
                        // their last values otherwise.
                        wen   <= 1'b1;
                        waddr <= in_rd;
                        wdata <= alu_result;
                    end
                end
            end else begin
                acc   <= acc_next;
                mul_a <= mul_a << 1;
                mul_b <= mul_b >> 1;
                cnt   <= cnt + 1'b1;
                if (last_iter) begin
                    state <= IDLE;
                    if (mul_rd != '0) begin
                        wen   <= 1'b1;
                        waddr <= mul_rd;
                        wdata <= acc_next;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_stage
//
// Bench for alu_exec_stage. Models the register file around the stage
// (combinational reads with same-cycle write forwarding, writes on wen).
// A reference model computes each instruction's result from an architectural
// register array in program order. Expected write-backs are queued at issue
// time and popped by an independent monitor whenever wen is seen.
// -----------------------------------------------------------------------------
module tb_alu_exec_stage;

    localparam int DSIZE = 16;
    localparam int ASIZE = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [ASIZE-1:0] in_rs1;
    logic [ASIZE-1:0] in_rs2;
    logic [ASIZE-1:0] in_rd;
    logic [ASIZE-1:0] raddr1;
    logic [ASIZE-1:0] raddr2;
    logic [DSIZE-1:0] rdata1;
    logic [DSIZE-1:0] rdata2;
    logic             wen;
    logic [ASIZE-1:0] waddr;
    logic [DSIZE-1:0] wdata;
    logic             busy;

    alu_exec_stage #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_rs1   (in_rs1),
        .in_rs2   (in_rs2),
        .in_rd    (in_rd),
        .raddr1   (raddr1),
        .raddr2   (raddr2),
        .rdata1   (rdata1),
        .rdata2   (rdata2),
        .wen      (wen),
        .waddr    (waddr),
        .wdata    (wdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file environment.
    logic [DSIZE-1:0] rf [16];
    assign rdata1 = (wen && waddr == raddr1) ? wdata : rf[raddr1];
    assign rdata2 = (wen && waddr == raddr2) ? wdata : rf[raddr2];
    always @(posedge clk) begin
        if (wen) rf[waddr] <= wdata;
    end

    // Reference model state.
    logic [DSIZE-1:0] model_regs [16];

    typedef struct {
        logic [ASIZE-1:0] rd;
        logic [DSIZE-1:0] data;
    } wb_t;
    wb_t exp_q[$];

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [DSIZE-1:0] model(input logic [2:0] op, input logic [DSIZE-1:0] a,
                                               input logic [DSIZE-1:0] b);
        int unsigned p;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            3'd6: begin
                p = int'(a) * int'(b);
                return p[15:0];
            end
            default: return 16'd0;
        endcase
    endfunction

    // Offer one instruction starting at a negedge; returns at the negedge
    // after the accept edge. commit=0 means the result must never appear.
    task automatic issue(input logic [2:0] op, input logic [ASIZE-1:0] rd, input logic [ASIZE-1:0] rs1,
                         input logic [ASIZE-1:0] rs2, input bit commit);
        logic [DSIZE-1:0] r;
        int waitc;
        r = model(op, model_regs[rs1], model_regs[rs2]);
        if (commit && op != 3'd7 && rd != '0) begin
            exp_q.push_back('{rd: rd, data: r});
            model_regs[rd] = r;
        end
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        waitc    = 0;
        while (!in_ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_op    = 3'($urandom);
        in_rd    = 4'($urandom);
        in_rs1   = 4'($urandom);
        in_rs2   = 4'($urandom);
    endtask

    // Monitor: every write-back must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && wen) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wen", 32'(wen), 32'd0);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                check("wb_addr", 32'(waddr), 32'(e.rd));
                check("wb_data", 32'(wdata), 32'(e.data));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_op    = 3'd7;
        in_rd    = '0;
        in_rs1   = '0;
        in_rs2   = '0;
        rf[0] = '0;
        for (int i = 1; i < 16; i++) rf[i] = 16'($urandom);
        rf[1] = 16'd5;
        rf[2] = 16'd2;
        for (int i = 0; i < 16; i++) model_regs[i] = rf[i];

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_wen",      32'(wen),      32'd0);
        check("rst_waddr",    32'(waddr),    32'd0);
        check("rst_wdata",    32'(wdata),    32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // ADD r3 = r1 + r2 = 7, single pulse.
        issue(3'd0, 4'd3, 4'd1, 4'd2, 1'b1);
        check("add_wen",   32'(wen),   32'd1);
        check("add_waddr", 32'(waddr), 32'd3);
        check("add_wdata", 32'(wdata), 32'd7);
        @(negedge clk);
        check("add_wen_drop", 32'(wen), 32'd0);

        // SUB r4 = 2 - 5 = 0xFFFD, then SLT r5 = (-3 < 5) = 1.
        issue(3'd1, 4'd4, 4'd2, 4'd1, 1'b1);
        check("sub_wdata", 32'(wdata), 32'h0000_FFFD);
        @(negedge clk);
        issue(3'd5, 4'd5, 4'd4, 4'd1, 1'b1);
        check("slt_wdata", 32'(wdata), 32'd1);
        @(negedge clk);

        // MUL r6 = 5 * 2: busy for 16 cycles, write-back with in_ready high.
        issue(3'd6, 4'd6, 4'd1, 4'd2, 1'b1);
        for (int i = 0; i < DSIZE; i++) begin
            check("mul_busy",     32'(busy),     32'd1);
            check("mul_in_ready", 32'(in_ready), 32'd0);
            check("mul_no_wen",   32'(wen),      32'd0);
            @(negedge clk);
        end
        check("mul_done_wen",   32'(wen),      32'd1);
        check("mul_done_waddr", 32'(waddr),    32'd6);
        check("mul_done_wdata", 32'(wdata),    32'd10);
        check("mul_done_ready", 32'(in_ready), 32'd1);
        check("mul_done_busy",  32'(busy),     32'd0);
        @(negedge clk);

        // Back-to-back dependent ADDs: 7 then 12 on consecutive cycles.
        issue(3'd0, 4'd3, 4'd1, 4'd2, 1'b1);
        check("b2b_first", 32'(wdata), 32'd7);
        issue(3'd0, 4'd7, 4'd3, 4'd1, 1'b1);
        check("b2b_second_wen", 32'(wen),   32'd1);
        check("b2b_second",     32'(wdata), 32'd12);
        @(negedge clk);

        // rd==0 and NOP never write.
        issue(3'd0, 4'd0, 4'd1, 4'd2, 1'b1);
        check("rd0_no_wen", 32'(wen), 32'd0);
        issue(3'd7, 4'd5, 4'd1, 4'd2, 1'b1);
        check("nop_no_wen", 32'(wen), 32'd0);
        @(negedge clk);

        // MUL aborted by asynchronous reset at iteration 8.
        issue(3'd6, 4'd8, 4'd1, 4'd2, 1'b0);
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy",     32'(busy),     32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_wen",      32'(wen),      32'd0);
        check("abort_waddr",    32'(waddr),    32'd0);
        check("abort_wdata",    32'(wdata),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Randomized instruction stream with random idle gaps.
        for (int n = 0; n < 300; n++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            if (op == 3'd6 && $urandom_range(0, 2) != 0) op = 3'($urandom_range(0, 5));
            issue(op, 4'($urandom), 4'($urandom), 4'($urandom), 1'b1);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        repeat (DSIZE + 4) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 16; i++) check("final_regs", 32'(rf[i]), 32'(model_regs[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute stage that sits directly downstream of the register file and closes the loop back into its write port.
- Accepts a decoded instruction over a valid/ready handshake and drives the register-file read addresses from it.
- Captures the returned operands and executes either a single-cycle ALU op or an iterative multi-cycle multiply.
- Returns the result as a one-cycle write-back (wen/waddr/wdata) to the register file.

Parameters:
- DSIZE, 16, datapath width; must match register-file data width.
- ASIZE, 4, register address width; must match register-file address width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset. Asynchronous, active-high: asserting rst clears all state immediately, independent of clk.
- in_valid  input  1  instruction offered.
- in_ready  output  1  stage can accept; high only in IDLE.
- in_op  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 MUL, 7 NOP.
- in_rs1  input  ASIZE  source register 1.
- in_rs2  input  ASIZE  source register 2.
- in_rd  input  ASIZE  destination register.
- raddr1  output  ASIZE  register-file read address 1; combinational copy of in_rs1.
- raddr2  output  ASIZE  register-file read address 2; combinational copy of in_rs2.
- rdata1  input  DSIZE  register-file read data 1; includes same-cycle write forwarding.
- rdata2  input  DSIZE  register-file read data 2; includes same-cycle write forwarding.
- wen  output  1  write-back enable; one-cycle pulse.
- waddr  output  ASIZE  write-back register.
- wdata  output  DSIZE  write-back data.
- busy  output  1  high while in MUL state.

Behaviour:
- Reset values: wen=0, waddr=0, wdata=0, busy=0, state=IDLE, in_ready=1, multiply counter/accumulator=0.
- Handshake: transfer occurs when in_valid && in_ready at a rising edge. Operands are sampled from rdata1/rdata2 on that same edge.
- States: IDLE, MUL.
- IDLE, single-cycle ops (0-5):
  - Result is registered at the accept edge.
  - wen=1, waddr=in_rd, wdata=result for exactly the following cycle.
  - State stays IDLE; back-to-back accepts every cycle are allowed.
- ADD/SUB: modulo 2^DSIZE, carry/borrow discarded.
- AND/OR/XOR: bitwise.
- SLT: wdata=1 if rdata1 < rdata2 as signed two's complement, else 0.
- NOP: accepted; no write (wen=0 next cycle).
- rd==0: write suppressed for every op (wen=0). Register 0 is never written by this stage.
- MUL accept:
  - Latch multiplicand A=rdata1, multiplier B=rdata2, rd. Clear accumulator; counter=0.
  - Next state MUL; in_ready=0; busy=1.
- MUL iteration, per edge:
  - If B[0], accumulator += A (mod 2^DSIZE).
  - A <<= 1, B >>= 1, counter++.
- MUL completion:
  - After exactly DSIZE iterations (edges 1..DSIZE after accept), state returns to IDLE at edge DSIZE.
  - In the cycle following that edge: wen=1, waddr=rd, wdata = low DSIZE bits of the product (unless rd==0), and in_ready=1.
  - A new instruction may be accepted in that same cycle.
- wen is never high for more than one cycle per instruction. Outside a write-back cycle, wen=0; waddr/wdata hold their last values.
- Dependent back-to-back instructions need no stall. When instruction N+1 is accepted in the cycle where N's write-back is on wen/waddr/wdata, the register file forwards wdata on the matching read port, so rdata already carries N's result.
- in_valid while in_ready=0: ignored. Upstream must hold the instruction until accepted.
- Reset mid-MUL: operation is aborted; no write-back is ever produced for it; state=IDLE immediately.
- in_* inputs are don't-care when in_valid=0. raddr1/raddr2 still follow in_rs1/in_rs2.

Test Plan:
- After reset (register file holds r1=5, r2=2), ADD rd=3 rs1=1 rs2=2 -> next cycle wen=1, waddr=3, wdata=7; following cycle wen=0.
- SUB rd=4 rs1=2 rs2=1 -> wdata=0xFFFD. SLT rd=5 rs1=4 rs2=1 (after SUB writes r4) -> wdata=1 (-3 < 5).
- MUL rd=6 rs1=1 rs2=2 -> in_ready=0 and busy=1 for 16 cycles; then wen=1, waddr=6, wdata=10, in_ready=1 in the same cycle.
- Back-to-back ADD r3=r1+r2 then ADD r7=r3+r1 on consecutive cycles, no stall -> write-backs 7 then 12 on consecutive cycles.
- rst asserted asynchronously at iteration 8 of a MUL -> outputs return to reset values immediately; no wen pulse ever appears for that MUL. ADD with rd=0 and NOP -> wen stays 0.
